// File: rtl/intc_pkg.sv
// intc_pkg: shared types and helpers for the interrupt controller.
//   - intc_state_e : controller FSM states (IDLE, REQ, SERVICE)
//   - VEC_W        : width of the handler address
//   - SRC_ID_W     : width of the source index
//   - intc_vector  : handler address for a given source index
package intc_pkg;

  localparam int VEC_W    = 16;
  localparam int SRC_ID_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intc_state_e;

  // base + stride * id, evaluated in VEC_W bits so it wraps modulo 2^16.
  function automatic logic [VEC_W-1:0] intc_vector(
    input logic [VEC_W-1:0]    base,
    input logic [VEC_W-1:0]    stride,
    input logic [SRC_ID_W-1:0] id
  );
    logic [VEC_W-1:0] id_ext;
    id_ext      = {{(VEC_W-SRC_ID_W){1'b0}}, id};
    intc_vector = base + stride * id_ext;
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: fixed-priority encoder, index 0 has highest priority.
// Ports:
//   req_i   [N-1:0]     request bits
//   grant_o [N-1:0]     one-hot grant of the lowest set request bit
//   valid_o             at least one request bit is set
//   idx_o   [SRC_ID_W]  index of the granted bit (0 when none)
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req_i,
  output logic [N-1:0]          grant_o,
  output logic                  valid_o,
  output logic [SRC_ID_W-1:0]   idx_o
);

  // Scan from the lowest priority upward so the lowest index is the last
  // assignment and therefore wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        idx_o      = SRC_ID_W'(i);
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-detects peripheral requests, masks them, picks
// the highest-priority eligible source and hands it to the control unit.
// Ports:
//   CLK, Reset_n        clock (rising edge), async active-low reset
//   IrqIn     [NUM_SRC] raw request lines; rising edge posts a request
//   MaskWrite, MaskIn   load the per-source enable mask (1 = enabled)
//   GieWrite,  GieIn    load the global interrupt enable
//   IntAck              control unit accepts the current request
//   IntDone             handler finished (return-from-interrupt)
//   IntReq              request to the control unit
//   Vector    [16]      handler address, held from REQ through SERVICE
//   SrcId     [4]       index of the source requested or in service
//   Pending   [NUM_SRC] latched pending bits
//   InService           handler active
//   DbgState  [2]       current FSM state, for observation only
//
// Handshake: IntReq stays high, with Vector/SrcId stable, until IntAck is
// sampled high at a clock edge; that edge is the transfer. IntAck in any
// other state and IntDone outside SERVICE are ignored.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int              NUM_SRC     = 4,
  parameter logic [VEC_W-1:0] VECTOR_BASE = 16'h0010,
  parameter int unsigned     VEC_STRIDE  = 2
) (
  input  logic                  CLK,
  input  logic                  Reset_n,
  input  logic [NUM_SRC-1:0]    IrqIn,
  input  logic                  MaskWrite,
  input  logic [NUM_SRC-1:0]    MaskIn,
  input  logic                  GieWrite,
  input  logic                  GieIn,
  input  logic                  IntAck,
  input  logic                  IntDone,
  output logic                  IntReq,
  output logic [VEC_W-1:0]      Vector,
  output logic [SRC_ID_W-1:0]   SrcId,
  output logic [NUM_SRC-1:0]    Pending,
  output logic                  InService,
  output logic [1:0]            DbgState
);

  intc_state_e          state_q, state_d;
  logic [NUM_SRC-1:0]   prev_q;
  logic [NUM_SRC-1:0]   pend_q, pend_d;
  logic [NUM_SRC-1:0]   mask_q;
  logic                 gie_q;
  logic [NUM_SRC-1:0]   sel_q, sel_d;
  logic [SRC_ID_W-1:0]  src_q, src_d;
  logic [VEC_W-1:0]     vec_q, vec_d;

  logic [NUM_SRC-1:0]   eligible;
  logic [NUM_SRC-1:0]   win_grant;
  logic                 win_valid;
  logic [SRC_ID_W-1:0]  win_idx;
  logic [NUM_SRC-1:0]   irq_rise;
  logic [NUM_SRC-1:0]   pend_clr;

  assign eligible = pend_q & mask_q & {NUM_SRC{gie_q}};
  assign irq_rise = IrqIn & ~prev_q;

  intc_prio_enc #(.N(NUM_SRC)) u_prio_enc (
    .req_i   (eligible),
    .grant_o (win_grant),
    .valid_o (win_valid),
    .idx_o   (win_idx)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    src_d    = src_q;
    vec_d    = vec_q;
    pend_clr = '0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          sel_d   = win_grant;
          src_d   = win_idx;
          vec_d   = intc_vector(VECTOR_BASE, VEC_W'(VEC_STRIDE), win_idx);
          state_d = REQ;
        end
      end
      REQ: begin
        // Committed: only IntAck moves us on; mask/GIE/new arrivals ignored.
        if (IntAck) begin
          pend_clr = sel_q;
          state_d  = SERVICE;
        end
      end
      SERVICE: begin
        if (IntDone) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A fresh edge on the bit being acknowledged re-posts it (set wins).
  assign pend_d = (pend_q & ~pend_clr) | irq_rise;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      prev_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      gie_q   <= 1'b0;
      sel_q   <= '0;
      src_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= IrqIn;
      pend_q  <= pend_d;
      if (MaskWrite) mask_q <= MaskIn;
      if (GieWrite)  gie_q  <= GieIn;
      sel_q   <= sel_d;
      src_q   <= src_d;
      vec_q   <= vec_d;
    end
  end

  assign IntReq    = (state_q == REQ);
  assign InService = (state_q == SERVICE);
  assign Vector    = vec_q;
  assign SrcId     = src_q;
  assign Pending   = pend_q;
  assign DbgState  = state_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: a table of per-cycle vectors with
// hand-computed expected outputs, plus hand-written sequences for the
// held-level, ignored-handshake and asynchronous-reset cases.
module tb_interrupt_controller;
  import intc_pkg::*;

  localparam int NS = 4;

  typedef struct {
    logic [NS-1:0] irq;
    logic          mwe;
    logic [NS-1:0] mask;
    logic          gwe;
    logic          gie;
    logic          ack;
    logic          done;
    logic          e_req;
    logic          e_svc;
    logic [3:0]    e_src;
    logic [15:0]   e_vec;
    logic [NS-1:0] e_pend;
  } vec_t;

  // clock / reset
  logic CLK = 1'b0;
  logic Reset_n = 1'b0;
  always #5 CLK = ~CLK;

  logic [NS-1:0] IrqIn = '0;
  logic          MaskWrite = 1'b0;
  logic [NS-1:0] MaskIn = '0;
  logic          GieWrite = 1'b0;
  logic          GieIn = 1'b0;
  logic          IntAck = 1'b0;
  logic          IntDone = 1'b0;
  logic          IntReq;
  logic [15:0]   Vector;
  logic [3:0]    SrcId;
  logic [NS-1:0] Pending;
  logic          InService;
  logic [1:0]    DbgState;

  interrupt_controller #(
    .NUM_SRC     (NS),
    .VECTOR_BASE (16'h0010),
    .VEC_STRIDE  (2)
  ) dut (
    .CLK       (CLK),
    .Reset_n   (Reset_n),
    .IrqIn     (IrqIn),
    .MaskWrite (MaskWrite),
    .MaskIn    (MaskIn),
    .GieWrite  (GieWrite),
    .GieIn     (GieIn),
    .IntAck    (IntAck),
    .IntDone   (IntDone),
    .IntReq    (IntReq),
    .Vector    (Vector),
    .SrcId     (SrcId),
    .Pending   (Pending),
    .InService (InService),
    .DbgState  (DbgState)
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [NS-1:0] irq, input logic mwe, input logic [NS-1:0] mask,
    input logic gwe, input logic gie, input logic ack, input logic done,
    input logic req, input logic svc, input logic [3:0] src,
    input logic [15:0] vec, input logic [NS-1:0] pend);
    vec_t v;
    v.irq = irq; v.mwe = mwe; v.mask = mask; v.gwe = gwe; v.gie = gie;
    v.ack = ack; v.done = done;
    v.e_req = req; v.e_svc = svc; v.e_src = src; v.e_vec = vec; v.e_pend = pend;
    return v;
  endfunction

  // driver: drive at negedge, let one rising edge happen, compare 1 ns later
  task automatic apply(input vec_t v, input string tag);
    @(negedge CLK);
    IrqIn = v.irq; MaskWrite = v.mwe; MaskIn = v.mask;
    GieWrite = v.gwe; GieIn = v.gie; IntAck = v.ack; IntDone = v.done;
    @(posedge CLK);
    #1;
    check({tag, " IntReq"},    16'(IntReq),    16'(v.e_req));
    check({tag, " InService"}, 16'(InService), 16'(v.e_svc));
    check({tag, " SrcId"},     16'(SrcId),     16'(v.e_src));
    check({tag, " Vector"},    Vector,         v.e_vec);
    check({tag, " Pending"},   16'(Pending),   16'(v.e_pend));
  endtask

  initial begin
    vec_t v;

    // test 1: single source 2
    vecs.push_back(mk(4'h0,1,4'hF,1,1,0,0, 0,0,0,16'h0000,4'h0));
    vecs.push_back(mk(4'h4,0,4'h0,0,0,0,0, 0,0,0,16'h0000,4'h4));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,0,0, 1,0,2,16'h0014,4'h4));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,1,0, 0,1,2,16'h0014,4'h0));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,0,1, 0,0,2,16'h0014,4'h0));
    // test 2: sources 3 and 1 together, 1 first
    vecs.push_back(mk(4'hA,0,4'h0,0,0,0,0, 0,0,2,16'h0014,4'hA));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,0,0, 1,0,1,16'h0012,4'hA));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,1,0, 0,1,1,16'h0012,4'h8));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,0,0, 0,1,1,16'h0012,4'h8));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,0,1, 0,0,1,16'h0012,4'h8));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,0,0, 1,0,3,16'h0016,4'h8));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,1,0, 0,1,3,16'h0016,4'h0));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,0,1, 0,0,3,16'h0016,4'h0));
    // test 3: GIE off holds the request back
    vecs.push_back(mk(4'h1,0,4'h0,1,0,0,0, 0,0,3,16'h0016,4'h1));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,0,0, 0,0,3,16'h0016,4'h1));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,0,0, 0,0,3,16'h0016,4'h1));
    vecs.push_back(mk(4'h0,0,4'h0,1,1,0,0, 0,0,3,16'h0016,4'h1));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,0,0, 1,0,0,16'h0010,4'h1));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,1,0, 0,1,0,16'h0010,4'h0));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,0,1, 0,0,0,16'h0010,4'h0));
    // test 4: committed request survives mask clear and higher arrival
    vecs.push_back(mk(4'h4,0,4'h0,0,0,0,0, 0,0,0,16'h0010,4'h4));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,0,0, 1,0,2,16'h0014,4'h4));
    vecs.push_back(mk(4'h1,1,4'hB,0,0,0,0, 1,0,2,16'h0014,4'h5));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,0,0, 1,0,2,16'h0014,4'h5));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,1,0, 0,1,2,16'h0014,4'h1));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,0,1, 0,0,2,16'h0014,4'h1));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,0,0, 1,0,0,16'h0010,4'h1));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,1,0, 0,1,0,16'h0010,4'h0));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,0,1, 0,0,0,16'h0010,4'h0));
    // test 5: new edge on the acknowledged source in the ack cycle re-posts
    vecs.push_back(mk(4'h4,1,4'hF,0,0,0,0, 0,0,0,16'h0010,4'h4));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,0,0, 1,0,2,16'h0014,4'h4));
    vecs.push_back(mk(4'h4,0,4'h0,0,0,1,0, 0,1,2,16'h0014,4'h4));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,0,1, 0,0,2,16'h0014,4'h4));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,0,0, 1,0,2,16'h0014,4'h4));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,1,0, 0,1,2,16'h0014,4'h0));
    vecs.push_back(mk(4'h0,0,4'h0,0,0,0,1, 0,0,2,16'h0014,4'h0));

    // reset
    repeat (3) @(posedge CLK);
    #1;
    check("reset IntReq",    16'(IntReq),    16'h0);
    check("reset InService", 16'(InService), 16'h0);
    check("reset SrcId",     16'(SrcId),     16'h0);
    check("reset Vector",    Vector,         16'h0);
    check("reset Pending",   16'(Pending),   16'h0);
    check("reset DbgState",  16'(DbgState),  16'(IDLE));
    @(negedge CLK);
    Reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("row%0d", i));

    // held level on IrqIn[1]: one post only; IntAck in IDLE and IntDone in
    // REQ are ignored
    for (int c = 0; c < 10; c++) begin
      logic ack, done, req, svc;
      logic [3:0] src;
      logic [15:0] vec;
      logic [NS-1:0] pend;
      ack  = (c == 1) || (c == 3);
      done = (c == 2) || (c == 9);
      if (c == 0)      begin req = 0; svc = 0; src = 2; vec = 16'h0014; pend = 4'h2; end
      else if (c <= 2) begin req = 1; svc = 0; src = 1; vec = 16'h0012; pend = 4'h2; end
      else if (c <= 8) begin req = 0; svc = 1; src = 1; vec = 16'h0012; pend = 4'h0; end
      else             begin req = 0; svc = 0; src = 1; vec = 16'h0012; pend = 4'h0; end
      v = mk(4'h2,0,4'h0,0,0,ack,done, req,svc,src,vec,pend);
      apply(v, $sformatf("held%0d", c));
    end
    for (int c = 0; c < 2; c++)
      apply(mk(4'h0,0,4'h0,0,0,0,0, 0,0,1,16'h0012,4'h0), $sformatf("heldrel%0d", c));

    // reset during SERVICE
    apply(mk(4'h8,0,4'h0,0,0,0,0, 0,0,1,16'h0012,4'h8), "rs0");
    apply(mk(4'h0,0,4'h0,0,0,0,0, 1,0,3,16'h0016,4'h8), "rs1");
    apply(mk(4'h4,0,4'h0,0,0,1,0, 0,1,3,16'h0016,4'h4), "rs2");
    @(negedge CLK);
    IrqIn = '0; IntAck = 1'b0; IntDone = 1'b0;
    Reset_n = 1'b0;
    #1;
    check("async IntReq",    16'(IntReq),    16'h0);
    check("async InService", 16'(InService), 16'h0);
    check("async SrcId",     16'(SrcId),     16'h0);
    check("async Vector",    Vector,         16'h0);
    check("async Pending",   16'(Pending),   16'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    Reset_n = 1'b1;
    // mask and GIE are cleared, so a new edge only posts
    apply(mk(4'h1,0,4'h0,0,0,0,0, 0,0,0,16'h0000,4'h1), "post0");
    for (int c = 0; c < 3; c++)
      apply(mk(4'h0,0,4'h0,0,0,0,0, 0,0,0,16'h0000,4'h1), $sformatf("post%0d", c + 1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
